// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants, FSM encodings and address-range helper
// for the two-port data-memory arbiter.
//   LEN_REGISTER      : data/address word width
//   ENABLE / DISABLE  : single-bit flag constants
//   arb_state_e       : ARB_IDLE / ARB_ACCESS / ARB_DONE
//   addr_in_range()   : word-aligned window check used by the optional
//                       address check (MEM_ARB_ADDR_CHECK_EN)
package mem_arbiter_pkg;

  localparam int   LEN_REGISTER = 32;
  localparam logic ENABLE       = 1'b1;
  localparam logic DISABLE      = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  function automatic logic addr_in_range(
    input logic [LEN_REGISTER-1:0] addr,
    input logic [LEN_REGISTER-1:0] base,
    input logic [LEN_REGISTER-1:0] depth_words
  );
    logic [LEN_REGISTER-1:0] limit;
    limit = base + (depth_words << 2);
    return (addr >= base) && (addr < limit) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side signals of the arbiter.
//   slave  : arbiter view (requests and memory read data in; acks, read data,
//            error, stall and memory strobes/address/data out)
//   master : requester/memory view (mirror of slave)
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic [1:0]              req_in;
  logic [1:0]              we_in;
  logic [LEN_REGISTER-1:0] addr0_in;
  logic [LEN_REGISTER-1:0] addr1_in;
  logic [LEN_REGISTER-1:0] wdata0_in;
  logic [LEN_REGISTER-1:0] wdata1_in;
  logic [1:0]              ack_out;
  logic [LEN_REGISTER-1:0] rdata_out;
  logic                    err_out;
  logic [1:0]              stall_out;
  logic                    mem_read_out;
  logic                    mem_write_out;
  logic [LEN_REGISTER-1:0] mem_addr_out;
  logic [LEN_REGISTER-1:0] mem_wdata_out;
  logic [LEN_REGISTER-1:0] mem_rdata_in;

  modport slave (
    input  req_in, we_in, addr0_in, addr1_in, wdata0_in, wdata1_in, mem_rdata_in,
    output ack_out, rdata_out, err_out, stall_out,
           mem_read_out, mem_write_out, mem_addr_out, mem_wdata_out
  );

  modport master (
    output req_in, we_in, addr0_in, addr1_in, wdata0_in, wdata1_in, mem_rdata_in,
    input  ack_out, rdata_out, err_out, stall_out,
           mem_read_out, mem_write_out, mem_addr_out, mem_wdata_out
  );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// mem_arbiter_rr_arbiter2: two-way round-robin grant.
//   clk, rst      : clock, async active-high reset
//   req_i[1:0]    : per-port request
//   grant_en_i    : grant is taken this cycle (updates last-grant history)
//   grant_valid_o : at least one request present
//   grant_id_o    : winning port (0/1)
module mem_arbiter_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  // Resets to 1 so port 0 wins the first contested grant.
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant_valid_o = |req_i;
    unique case (req_i)
      2'b01:   grant_id_o = 1'b0;
      2'b10:   grant_id_o = 1'b1;
      2'b11:   grant_id_o = ~last_grant_q;
      default: grant_id_o = 1'b0;
    endcase
    last_grant_d = (grant_en_i && grant_valid_o) ? grant_id_o : last_grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and access sequencer for the
// shared single-port data memory.
//   clk, rst : clock, async active-high reset
//   bus      : mem_arbiter_if.slave (requests, acks, read data, error,
//              stall, memory strobes/address/data)
// Optional build macro MEM_ARB_ADDR_CHECK_EN: out-of-window or misaligned
// addresses skip the memory and complete with err_out = 1.
//
// state      | meaning
// ARB_IDLE   | waiting for a request; grant and latch on request
// ARB_ACCESS | driving memory for WAIT_CYCLES+1 cycles
// ARB_DONE   | one-cycle ack to the granted port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned             WAIT_CYCLES = 2,
  parameter logic [LEN_REGISTER-1:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned             DEPTH_WORDS = 64
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

`ifdef MEM_ARB_ADDR_CHECK_EN
  localparam logic CHECK_EN = ENABLE;
`else
  localparam logic CHECK_EN = DISABLE;
`endif

  arb_state_e              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    port_q, port_d;
  logic                    we_q, we_d;
  logic                    err_q, err_d;
  logic [LEN_REGISTER-1:0] addr_q, addr_d;
  logic [LEN_REGISTER-1:0] wdata_q, wdata_d;
  logic [LEN_REGISTER-1:0] rdata_q, rdata_d;

  logic                    grant_en, grant_valid, grant_id;
  logic [LEN_REGISTER-1:0] grant_addr;
  logic                    grant_addr_ok;

  assign grant_en      = (state_q == ARB_IDLE) ? ENABLE : DISABLE;
  assign grant_addr    = grant_id ? bus.addr1_in : bus.addr0_in;
  assign grant_addr_ok = addr_in_range(grant_addr, BASE_ADDR, LEN_REGISTER'(DEPTH_WORDS));

  mem_arbiter_rr_arbiter2 u_rr (
    .clk          (clk),
    .rst          (rst),
    .req_i        (bus.req_in),
    .grant_en_i   (grant_en),
    .grant_valid_o(grant_valid),
    .grant_id_o   (grant_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:
        if (grant_valid) state_d = (CHECK_EN && !grant_addr_ok) ? ARB_DONE : ARB_ACCESS;
      ARB_ACCESS:
        if (cnt_q == 4'd0) state_d = ARB_DONE;
      ARB_DONE:
        state_d = ARB_IDLE;
      default:
        state_d = ARB_IDLE;
    endcase
  end

  // Datapath next-state; request-side inputs are only looked at while idle.
  always_comb begin
    cnt_d   = cnt_q;
    port_d  = port_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == ARB_IDLE && grant_valid) begin
      port_d  = grant_id;
      we_d    = bus.we_in[grant_id];
      addr_d  = grant_addr;
      wdata_d = grant_id ? bus.wdata1_in : bus.wdata0_in;
      cnt_d   = 4'(WAIT_CYCLES);
      err_d   = CHECK_EN && !grant_addr_ok;
      rdata_d = '0;
    end else if (state_q == ARB_ACCESS) begin
      if (cnt_q != 4'd0) cnt_d   = cnt_q - 4'd1;
      else               rdata_d = we_q ? '0 : bus.mem_rdata_in;
    end
  end

  always_comb begin
    bus.ack_out       = 2'b00;
    bus.rdata_out     = '0;
    bus.err_out       = 1'b0;
    bus.mem_read_out  = 1'b0;
    bus.mem_write_out = 1'b0;
    bus.mem_addr_out  = '0;
    bus.mem_wdata_out = '0;
    unique case (state_q)
      ARB_ACCESS: begin
        bus.mem_read_out  = ~we_q;
        // Write only in the last access cycle so the memory sees one write.
        bus.mem_write_out = we_q && (cnt_q == 4'd0);
        bus.mem_addr_out  = addr_q;
        bus.mem_wdata_out = wdata_q;
      end
      ARB_DONE: begin
        bus.ack_out[port_q] = 1'b1;
        bus.rdata_out       = rdata_q;
        bus.err_out         = CHECK_EN && err_q;
      end
      default: ;
    endcase
  end

  assign bus.stall_out = bus.req_in & ~bus.ack_out;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  mem_arbiter_if ifc ();
  mem_arbiter_if ifz ();

  mem_arbiter #(.WAIT_CYCLES(2)) u_dut (.clk(clk), .rst(rst), .bus(ifc));
  mem_arbiter #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(ifz));

  // Simple data memory behind the WAIT_CYCLES=2 instance.
  logic [31:0] mem [0:63];

  function automatic logic [5:0] widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'd1024;
    return o[7:2];
  endfunction

  always @(posedge clk)
    if (ifc.mem_write_out) mem[widx(ifc.mem_addr_out)] <= ifc.mem_wdata_out;

  assign ifc.mem_rdata_in = (ifc.mem_addr_out >= 32'd1024 && ifc.mem_addr_out < 32'd1280)
                            ? mem[widx(ifc.mem_addr_out)] : 32'hBAD0_0BAD;
  assign ifz.mem_rdata_in = 32'h1234_5678;

  // Issue one access on ifc and observe it until ack (bounded).
  task automatic run_access(input logic port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat, output logic [1:0] ack_v,
                            output logic [31:0] rdata_v, output logic err_v, output int n_wr,
                            output int n_rd, output logic [31:0] wr_addr,
                            output logic [31:0] wr_data, output logic stall_ok);
    lat = -1; ack_v = 2'b00; rdata_v = '0; err_v = 1'b0; n_wr = 0; n_rd = 0;
    wr_addr = '0; wr_data = '0; stall_ok = 1'b1;
    @(negedge clk);
    ifc.we_in[port] = we;
    if (port) begin ifc.addr1_in = addr; ifc.wdata1_in = wdata; end
    else      begin ifc.addr0_in = addr; ifc.wdata0_in = wdata; end
    ifc.req_in[port] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc.mem_write_out) begin n_wr++; wr_addr = ifc.mem_addr_out; wr_data = ifc.mem_wdata_out; end
      if (ifc.mem_read_out) n_rd++;
      if (ifc.ack_out != 2'b00) begin
        lat = i; ack_v = ifc.ack_out; rdata_v = ifc.rdata_out; err_v = ifc.err_out;
        if (ifc.stall_out[port] !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (ifc.stall_out[port] !== 1'b1) stall_ok = 1'b0;
    end
    ifc.req_in = 2'b00;
  endtask

  task automatic test_reset();
    #12;
    tests++; if (ifc.ack_out !== 2'b00) begin fails++; $display("FAIL reset_ack got %b want 00", ifc.ack_out); end
    tests++; if ({ifc.mem_read_out, ifc.mem_write_out, ifc.err_out} !== 3'b000) begin fails++;
      $display("FAIL reset_strobes got %b want 000", {ifc.mem_read_out, ifc.mem_write_out, ifc.err_out}); end
    tests++; if ({ifc.mem_addr_out, ifc.mem_wdata_out, ifc.rdata_out} !== 96'd0) begin fails++;
      $display("FAIL reset_data got %h %h %h want 0", ifc.mem_addr_out, ifc.mem_wdata_out, ifc.rdata_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write();
    int lat, n_wr, n_rd; logic [1:0] ack; logic [31:0] rd, wa, wd; logic err, st;
    run_access(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, lat, ack, rd, err, n_wr, n_rd, wa, wd, st);
    tests++; if (lat !== 4) begin fails++; $display("FAIL wr_latency got %0d want 4", lat); end
    tests++; if (ack !== 2'b01) begin fails++; $display("FAIL wr_ack got %b want 01", ack); end
    tests++; if (n_wr !== 1) begin fails++; $display("FAIL wr_count got %0d want 1", n_wr); end
    tests++; if (wa !== 32'd1028) begin fails++; $display("FAIL wr_addr got %0d want 1028", wa); end
    tests++; if (wd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_data got %h want deadbeef", wd); end
    tests++; if (n_rd !== 0) begin fails++; $display("FAIL wr_no_read got %0d want 0", n_rd); end
    tests++; if ({rd, err} !== 33'd0) begin fails++; $display("FAIL wr_rdata_err got %h %b want 0 0", rd, err); end
    tests++; if (st !== 1'b1) begin fails++; $display("FAIL wr_stall got %b want 1", st); end
  endtask

  task automatic test_read();
    int lat, n_wr, n_rd; logic [1:0] ack; logic [31:0] rd, wa, wd; logic err, st;
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, lat, ack, rd, err, n_wr, n_rd, wa, wd, st);
    tests++; if (lat !== 4) begin fails++; $display("FAIL rd_latency got %0d want 4", lat); end
    tests++; if (ack !== 2'b10) begin fails++; $display("FAIL rd_ack got %b want 10", ack); end
    tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data got %h want deadbeef", rd); end
    tests++; if (n_rd !== 3 || n_wr !== 0) begin fails++; $display("FAIL rd_strobes got rd=%0d wr=%0d want 3 0", n_rd, n_wr); end
    tests++; if (st !== 1'b1) begin fails++; $display("FAIL rd_stall got %b want 1", st); end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [4];
    int at [4];
    int n = 0;
    logic [31:0] rds [4];
    @(negedge clk);
    ifc.we_in = 2'b00; ifc.addr0_in = 32'd1028; ifc.addr1_in = 32'd1028;
    ifc.req_in = 2'b11;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc.ack_out != 2'b00) begin seq[n] = ifc.ack_out; at[n] = c; rds[n] = ifc.rdata_out; n++; end
    end
    ifc.req_in = 2'b00;
    tests++; if (n !== 4) begin fails++; $display("FAIL rr_count got %0d want 4", n); end
    else begin
      tests++; if ({seq[0], seq[1], seq[2], seq[3]} !== 8'b01_10_01_10) begin fails++;
        $display("FAIL rr_order got %b %b %b %b want 01 10 01 10", seq[0], seq[1], seq[2], seq[3]); end
      tests++; if (at[0] !== 4 || at[1] - at[0] !== 5 || at[3] - at[2] !== 5) begin fails++;
        $display("FAIL rr_timing got %0d %0d %0d %0d want 4 9 14 19", at[0], at[1], at[2], at[3]); end
      tests++; if (rds[1] !== 32'hDEAD_BEEF || rds[2] !== 32'hDEAD_BEEF) begin fails++;
        $display("FAIL rr_rdata got %h %h want deadbeef", rds[1], rds[2]); end
    end
  endtask

  task automatic test_reset_mid();
    int n_ack = 0, n_wr = 0;
    logic [1:0] first = 2'b00;
    @(negedge clk);
    ifc.we_in = 2'b01; ifc.addr0_in = 32'd1032; ifc.wdata0_in = 32'h1111_2222;
    ifc.req_in = 2'b01;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if ({ifc.ack_out, ifc.mem_read_out, ifc.mem_write_out, ifc.err_out} !== 5'd0) begin fails++;
      $display("FAIL rstmid_ctrl got %b want 00000", {ifc.ack_out, ifc.mem_read_out, ifc.mem_write_out, ifc.err_out}); end
    tests++; if ({ifc.mem_addr_out, ifc.mem_wdata_out, ifc.rdata_out} !== 96'd0) begin fails++;
      $display("FAIL rstmid_data got %h %h %h want 0", ifc.mem_addr_out, ifc.mem_wdata_out, ifc.rdata_out); end
    ifc.req_in = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ifc.ack_out != 2'b00) n_ack++;
      if (ifc.mem_write_out) n_wr++;
      if (i == 1) rst = 1'b0;
    end
    tests++; if (n_ack !== 0 || n_wr !== 0) begin fails++; $display("FAIL rstmid_quiet got ack=%0d wr=%0d want 0 0", n_ack, n_wr); end
    // last_grant was 0 before reset; reset brings it back to 1, so port 0 wins.
    @(negedge clk);
    ifc.we_in = 2'b00; ifc.addr0_in = 32'd1028; ifc.addr1_in = 32'd1028;
    ifc.req_in = 2'b11;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc.ack_out != 2'b00) begin first = ifc.ack_out; break; end
    end
    ifc.req_in = 2'b00;
    tests++; if (first !== 2'b01) begin fails++; $display("FAIL rstmid_lastgrant got %b want 01", first); end
    @(negedge clk);
  endtask

  task automatic test_wait0();
    int lat = -1, n_rd = 0;
    logic [31:0] rd = '0;
    logic [1:0] ack = 2'b00;
    @(negedge clk);
    ifz.we_in = 2'b00; ifz.addr0_in = 32'd1100; ifz.req_in = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifz.mem_read_out) n_rd++;
      if (ifz.ack_out != 2'b00) begin lat = i; ack = ifz.ack_out; rd = ifz.rdata_out; break; end
    end
    ifz.req_in = 2'b00;
    tests++; if (lat !== 2) begin fails++; $display("FAIL w0_latency got %0d want 2", lat); end
    tests++; if (ack !== 2'b01 || rd !== 32'h1234_5678) begin fails++; $display("FAIL w0_ack_data got %b %h want 01 12345678", ack, rd); end
    tests++; if (n_rd !== 1) begin fails++; $display("FAIL w0_reads got %0d want 1", n_rd); end
  endtask

  task automatic test_addr_check();
    int lat, n_wr, n_rd; logic [1:0] ack; logic [31:0] rd, wa, wd; logic err, st;
    logic [31:0] addrs [2];
    addrs[0] = 32'd1280; addrs[1] = 32'd1026;
    for (int k = 0; k < 2; k++) begin
      run_access(1'b0, 1'b0, addrs[k], 32'h0, lat, ack, rd, err, n_wr, n_rd, wa, wd, st);
`ifdef MEM_ARB_ADDR_CHECK_EN
      tests++; if (lat !== 1 || ack !== 2'b01) begin fails++; $display("FAIL ac_latency a=%0d got %0d %b want 1 01", addrs[k], lat, ack); end
      tests++; if (err !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL ac_err a=%0d got %b %h want 1 0", addrs[k], err, rd); end
      tests++; if (n_rd !== 0 || n_wr !== 0) begin fails++; $display("FAIL ac_strobes a=%0d got %0d %0d want 0 0", addrs[k], n_rd, n_wr); end
`else
      tests++; if (lat !== 4 || ack !== 2'b01) begin fails++; $display("FAIL ac_latency a=%0d got %0d %b want 4 01", addrs[k], lat, ack); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL ac_err a=%0d got %b want 0", addrs[k], err); end
      tests++; if (n_rd !== 3 || n_wr !== 0) begin fails++; $display("FAIL ac_strobes a=%0d got %0d %0d want 3 0", addrs[k], n_rd, n_wr); end
`endif
    end
  endtask

  initial begin
    ifc.req_in = 2'b00; ifc.we_in = 2'b00;
    ifc.addr0_in = '0; ifc.addr1_in = '0; ifc.wdata0_in = '0; ifc.wdata1_in = '0;
    ifz.req_in = 2'b00; ifz.we_in = 2'b00;
    ifz.addr0_in = '0; ifz.addr1_in = '0; ifz.wdata0_in = '0; ifz.wdata1_in = '0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_reset_mid();
    test_wait0();
    test_addr_check();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
